// File: rtl/sampler_pkg.sv
// Shared definitions for the keyboard sampler audio path: code width, envelope
// states and the note half-period table.
package sampler_pkg;

    localparam int SOUND_W  = 3;
    localparam int SAMPLE_W = 16;
    localparam int HALF_W   = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } env_state_t;

    // Half period in sample ticks for C4 E4 G4 C5 E5 G5 C6; code 0 never sounds.
    function automatic logic [HALF_W-1:0] half_period(input logic [SOUND_W-1:0] code);
        case (code)
            3'd1:    return 7'd92;
            3'd2:    return 7'd73;
            3'd3:    return 7'd61;
            3'd4:    return 7'd46;
            3'd5:    return 7'd36;
            3'd6:    return 7'd31;
            3'd7:    return 7'd23;
            default: return 7'd1;
        endcase
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Divides CLOCK_50 down to a one-cycle sample tick every DIV cycles.
module sample_tick_gen #(
    parameter int DIV = 1042
) (
    input  logic CLOCK_50,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] tick_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge CLOCK_50) begin
        if (reset)
            tick_cnt <= '0;
        else if (tick_cnt == LAST)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    assign tick = (tick_cnt == LAST);

endmodule

// File: rtl/tone_synth.sv
// Square-wave note synthesizer with linear attack/release envelope and a
// valid/ready PCM output. Optional TONE_SYNTH_CODE_FILTER_EN debounces codes.
module tone_synth
    import sampler_pkg::*;
#(
    parameter int               SAMPLE_DIV = 1042,
    parameter int               AMP_W      = SAMPLE_W,
    parameter logic [AMP_W-1:0] AMP_MAX    = 16'h3000,
    parameter logic [AMP_W-1:0] ENV_STEP   = 16'h0100
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [SOUND_W-1:0] sound,
    input  logic               sample_ready,
    output logic               sample_valid,
    output logic [AMP_W-1:0]   sample,
    output logic               overrun,
    output logic               busy
);

    localparam logic [AMP_W-2:0] MAX_N  = AMP_MAX[AMP_W-2:0];
    localparam logic [AMP_W-2:0] STEP_N = ENV_STEP[AMP_W-2:0];

    logic               tick;
    logic               tick_d;
    env_state_t         state;
    logic [SOUND_W-1:0] note;
    logic [SOUND_W-1:0] code;
    logic [HALF_W-1:0]  half_cnt;
    logic [HALF_W-1:0]  hp;
    logic [AMP_W-2:0]   amp;
    logic [AMP_W-2:0]   amp_up;
    logic [AMP_W-2:0]   amp_dn;
    logic [AMP_W-1:0]   amp_ext;
    logic               sq;

    sample_tick_gen #(.DIV(SAMPLE_DIV)) u_tick (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .tick     (tick)
    );

`ifdef TONE_SYNTH_CODE_FILTER_EN
    logic [SOUND_W-1:0] code_prev;
    logic [SOUND_W-1:0] code_acc;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            code_prev <= '0;
            code_acc  <= '0;
        end else if (tick) begin
            code_prev <= sound;
            code_acc  <= code;
        end
    end

    // A code takes effect only once it matches the one seen on the previous tick.
    assign code = (sound == code_prev) ? sound : code_acc;
`else
    assign code = sound;
`endif

    assign hp      = half_period(note);
    assign amp_ext = {1'b0, amp};
    // Saturation compares before the add so the sum can never wrap.
    assign amp_up  = (amp >= MAX_N - STEP_N) ? MAX_N : amp + STEP_N;
    assign amp_dn  = (amp <= STEP_N) ? '0 : amp - STEP_N;
    assign busy    = (state != IDLE);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state        <= IDLE;
            note         <= '0;
            half_cnt     <= '0;
            amp          <= '0;
            sq           <= 1'b0;
            tick_d       <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            tick_d <= tick;

            if (tick) begin
                if (state == IDLE) begin
                    if (code != '0) begin
                        note     <= code;
                        half_cnt <= '0;
                        sq       <= 1'b0;
                    end
                end else if (code != '0 && code != note) begin
                    // Pitch change keeps phase and level to avoid a click.
                    note     <= code;
                    half_cnt <= '0;
                end else if (half_cnt == hp - 7'd1) begin
                    half_cnt <= '0;
                    sq       <= ~sq;
                end else begin
                    half_cnt <= half_cnt + 7'd1;
                end

                case (state)
                    IDLE:
                        if (code != '0) state <= ATTACK;
                    ATTACK:
                        if (code == '0) begin
                            state <= RELEASE;
                        end else begin
                            amp <= amp_up;
                            if (amp_up == MAX_N) state <= SUSTAIN;
                        end
                    SUSTAIN:
                        if (code == '0) state <= RELEASE;
                    RELEASE:
                        if (code != '0) begin
                            state <= ATTACK;
                        end else begin
                            amp <= amp_dn;
                            if (amp_dn == '0) state <= IDLE;
                        end
                    default:
                        state <= IDLE;
                endcase
            end

            // Envelope and oscillator settle on the tick; publish one cycle later.
            if (tick_d) begin
                sample       <= sq ? amp_ext : -amp_ext;
                sample_valid <= 1'b1;
                if (sample_valid && !sample_ready) overrun <= 1'b1;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tone_synth.sv
// Directed bench for tone_synth with a short sample divider; expectations are
// hand-derived per tick index and shift by one tick in the filtered build.
module tb_tone_synth;

    localparam int DIV = 4;
`ifdef TONE_SYNTH_CODE_FILTER_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic        CLOCK_50     = 1'b0;
    logic        reset        = 1'b1;
    logic [2:0]  sound        = 3'b001;
    logic        sample_ready = 1'b1;
    logic        sample_valid;
    logic [15:0] sample;
    logic        overrun;
    logic        busy;

    int checks = 0;
    int passed = 0;

    tone_synth #(.SAMPLE_DIV(DIV)) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .sound        (sound),
        .sample_ready (sample_ready),
        .sample_valid (sample_valid),
        .sample       (sample),
        .overrun      (overrun),
        .busy         (busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic next_sample(output logic [15:0] s, output int cyc);
        s   = '0;
        cyc = 0;
        for (int i = 1; i <= 4 * DIV; i++) begin
            @(negedge CLOCK_50);
            if (sample_valid) begin
                s   = sample;
                cyc = i;
                break;
            end
        end
        if (cyc == 0) check("sample_timeout", {31'b0, sample_valid}, 32'd1);
    endtask

    function automatic logic [15:0] pcm(input int amp, input int sqv);
        int v;
        v = (sqv != 0) ? amp : -amp;
        return 16'(v);
    endfunction

    function automatic int attack_amp(input int k, input int a0);
        int v;
        if (k <= a0) return 0;
        v = (k - a0) * 256;
        return (v > 32'h3000) ? 32'h3000 : v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] s;
        int cyc, sqv, amp, a0, p0, r0, a1;

        repeat (3) begin
            @(negedge CLOCK_50);
            check("rst_valid",   {31'b0, sample_valid}, 32'd0);
            check("rst_sample",  {16'b0, sample},       32'd0);
            check("rst_busy",    {31'b0, busy},         32'd0);
            check("rst_overrun", {31'b0, overrun},      32'd0);
        end
        reset = 1'b0;

        a0 = 1 + LAT;
        for (int k = 1; k <= 190; k++) begin
            next_sample(s, cyc);
            if (k == 1) check("first_latency", 32'(cyc), 32'(DIV + 1));
            sqv = (k >= a0) ? ((k - a0) / 92) % 2 : 0;
            check("note001", {16'b0, s}, {16'b0, pcm(attack_amp(k, a0), sqv)});
        end
        check("sustain_busy", {31'b0, busy}, 32'd1);

        sound = 3'b111;
        p0 = 191 + LAT;
        for (int k = 191; k <= 240; k++) begin
            next_sample(s, cyc);
            sqv = (k < p0) ? 0 : ((k - p0) / 23) % 2;
            check("pitch111", {16'b0, s}, {16'b0, pcm(32'h3000, sqv)});
        end

        sound = 3'b000;
        r0 = 241 + LAT;
        for (int k = 241; k <= 291; k++) begin
            next_sample(s, cyc);
            amp = (k <= r0) ? 32'h3000 : 32'h3000 - (k - r0) * 256;
            if (amp < 0) amp = 0;
            sqv = ((k - p0) / 23) % 2;
            check("release", {16'b0, s}, {16'b0, pcm(amp, sqv)});
            check("release_busy", {31'b0, busy}, (k < r0 + 48) ? 32'd1 : 32'd0);
        end
        check("no_overrun", {31'b0, overrun}, 32'd0);

        sound = 3'b011;
        a1 = 292 + LAT;
        for (int k = 292; k <= 294; k++) begin
            next_sample(s, cyc);
            check("attack011", {16'b0, s}, {16'b0, pcm(attack_amp(k, a1), 0)});
        end
        @(negedge CLOCK_50);
        sample_ready = 1'b0;
        repeat (12) @(negedge CLOCK_50);
        check("ovr_valid",  {31'b0, sample_valid}, 32'd1);
        check("ovr_flag",   {31'b0, overrun},      32'd1);
        check("ovr_sample", {16'b0, sample},       {16'b0, pcm(attack_amp(297, a1), 0)});
        sample_ready = 1'b1;
        @(negedge CLOCK_50);
        check("ovr_drop",   {31'b0, sample_valid}, 32'd0);
        check("ovr_sticky", {31'b0, overrun},      32'd1);
        next_sample(s, cyc);
        check("after_ovr",  {16'b0, s},            {16'b0, pcm(attack_amp(298, a1), 0)});
        check("ovr_sticky2", {31'b0, overrun},     32'd1);

        sample_ready = 1'b0;
        reset = 1'b1;
        @(negedge CLOCK_50);
        check("mid_rst_busy",    {31'b0, busy},         32'd0);
        check("mid_rst_valid",   {31'b0, sample_valid}, 32'd0);
        check("mid_rst_sample",  {16'b0, sample},       32'd0);
        check("mid_rst_overrun", {31'b0, overrun},      32'd0);
        sound = 3'b000;
        sample_ready = 1'b1;
        reset = 1'b0;

        next_sample(s, cyc);
        check("glitch_t1", {31'b0, busy}, 32'd0);
        sound = 3'b010;
        next_sample(s, cyc);
        check("glitch_t2", {31'b0, busy}, (LAT != 0) ? 32'd0 : 32'd1);
        sound = 3'b000;
        next_sample(s, cyc);
        check("glitch_t3", {31'b0, busy}, (LAT != 0) ? 32'd0 : 32'd1);
        sound = 3'b010;
        next_sample(s, cyc);
        check("glitch_t4", {31'b0, busy}, (LAT != 0) ? 32'd0 : 32'd1);
        next_sample(s, cyc);
        check("glitch_t5", {31'b0, busy}, 32'd1);
        check("glitch_t5_sample", {16'b0, s}, (LAT != 0) ? 32'h0000 : 32'hFF00);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
